// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. It sends one command byte (for example
// 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the attached keyboard using the
// request-to-send sequence. The block drives the shared PS/2 clock and data
// lines through open-drain enables and reads the raw pin levels back. While
// busy_o is high, the keyboard receiver next to this block must ignore the bus.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset; releases both lines
//   tx_valid_i     command byte available
//   tx_data_i      command byte
//   tx_ready_o     high only in IDLE; accept on tx_valid_i & tx_ready_o
//   ps2_clk_i      raw PS/2 clock pin level (asynchronous)
//   ps2_data_i     raw PS/2 data pin level (asynchronous)
//   ps2_clk_oe_o   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe_o  1 = pull PS/2 data low, 0 = release
//   busy_o         high in every state except IDLE
//   tx_done_o      one-cycle pulse: byte sent and the device acked
//   tx_err_o       one-cycle pulse: missing ack (or watchdog timeout)
//
// Build option:
//   PS2_TX_TIMEOUT_EN  when defined, a watchdog aborts a transfer that has seen
//                      no PS/2 clock falling edge for TIMEOUT_CYCLES cycles.

module ps2_host_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o
);

  localparam int INHIBIT_CYCLES = CLK_FREQ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  // A zero-length inhibit or watchdog would break the protocol, so refuse to
  // elaborate with such a parameter set.
  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_badParams
    $error("ps2_host_tx: INHIBIT and TIMEOUT durations must be at least one clock cycle");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t           state_q;
  logic             clkOe_q;
  logic             dataOe_q;
  logic             txDone_q;
  logic             txErr_q;
  logic [7:0]       txData_q;
  logic             parity_q;
  logic             parity_d;
  logic [3:0]       bitCnt_q;
  logic [INH_W-1:0] inhCnt_q;
  logic             ackOk_q;

  logic             clkMeta_q;
  logic             clkSync_q;
  logic             clkHist_q;
  logic             dataMeta_q;
  logic             dataSync_q;
  logic             fallEdge;

  // Both pins are asynchronous and go through two flops. The clock pin also
  // gets a history flop so that a falling edge can be seen. The flops reset to
  // 1 because that is the idle level of the bus, which avoids a false edge
  // when reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkMeta_q  <= 1'b1;
      clkSync_q  <= 1'b1;
      clkHist_q  <= 1'b1;
      dataMeta_q <= 1'b1;
      dataSync_q <= 1'b1;
    end else begin
      clkMeta_q  <= ps2_clk_i;
      clkSync_q  <= clkMeta_q;
      clkHist_q  <= clkSync_q;
      dataMeta_q <= ps2_data_i;
      dataSync_q <= dataMeta_q;
    end
  end

  assign fallEdge = clkHist_q & ~clkSync_q;

  // Odd parity over the command byte. It is latched together with the byte.
  assign parity_d = ~^tx_data_i;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wdCnt_q;
`endif

  // Main transfer FSM. Every line change happens on a registered output, and
  // a change only follows a device clock falling edge. That way the data line
  // moves only while the device holds the clock low. When the watchdog is
  // built in, its block comes after the case statement, so an abort takes
  // priority over whatever the state logic scheduled in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      clkOe_q  <= 1'b0;
      dataOe_q <= 1'b0;
      txDone_q <= 1'b0;
      txErr_q  <= 1'b0;
      txData_q <= '0;
      parity_q <= 1'b0;
      bitCnt_q <= '0;
      inhCnt_q <= '0;
      ackOk_q  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wdCnt_q  <= '0;
`endif
    end else begin
      txDone_q <= 1'b0;
      txErr_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          clkOe_q  <= 1'b0;
          dataOe_q <= 1'b0;
          if (tx_valid_i) begin
            txData_q <= tx_data_i;
            parity_q <= parity_d;
            inhCnt_q <= '0;
            clkOe_q  <= 1'b1;
            state_q  <= S_INHIBIT;
          end
        end

        // The clock is held low for exactly INHIBIT_CYCLES cycles. The start
        // bit (data low) goes out on the same edge that releases the clock.
        S_INHIBIT: begin
          if (inhCnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
            clkOe_q  <= 1'b0;
            dataOe_q <= 1'b1;
            bitCnt_q <= 4'd0;
            state_q  <= S_RTS;
          end else begin
            inhCnt_q <= inhCnt_q + 1'b1;
          end
        end

        S_RTS: begin
          if (fallEdge) begin
            dataOe_q <= ~txData_q[0];
            bitCnt_q <= 4'd1;
            state_q  <= S_SHIFT;
          end
        end

        // bitCnt_q holds the number of edges seen so far. Edge n drives data
        // bit n-1 (edges 2..8), then parity (edge 9), then the stop bit is
        // released (edge 10).
        S_SHIFT: begin
          if (fallEdge) begin
            bitCnt_q <= bitCnt_q + 4'd1;
            if (bitCnt_q <= 4'd7) begin
              dataOe_q <= ~txData_q[bitCnt_q[2:0]];
            end else if (bitCnt_q == 4'd8) begin
              dataOe_q <= ~parity_q;
            end else begin
              dataOe_q <= 1'b0;
              state_q  <= S_ACK;
            end
          end
        end

        S_ACK: begin
          if (fallEdge) begin
            bitCnt_q <= 4'd11;
            ackOk_q  <= ~dataSync_q;
            clkOe_q  <= 1'b0;
            dataOe_q <= 1'b0;
            state_q  <= S_RELEASE;
          end
        end

        // Wait for the device to let go of both lines. The result pulse then
        // lands in the first IDLE cycle, and in that cycle tx_ready_o is
        // already high.
        S_RELEASE: begin
          if (clkSync_q & dataSync_q) begin
            txDone_q <= ackOk_q;
            txErr_q  <= ~ackOk_q;
            state_q  <= S_IDLE;
          end
        end

        default: begin
          clkOe_q  <= 1'b0;
          dataOe_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // The watchdog stays at zero in IDLE and INHIBIT, so it starts from zero
      // on entry to RTS. Every device clock edge restarts it.
      if (state_q != S_IDLE && state_q != S_INHIBIT) begin
        if (fallEdge) begin
          wdCnt_q <= '0;
        end else if (wdCnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          wdCnt_q  <= '0;
          clkOe_q  <= 1'b0;
          dataOe_q <= 1'b0;
          txDone_q <= 1'b0;
          txErr_q  <= 1'b1;
          state_q  <= S_IDLE;
        end else begin
          wdCnt_q <= wdCnt_q + 1'b1;
        end
      end else begin
        wdCnt_q <= '0;
      end
`endif
    end
  end

  assign tx_ready_o    = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign ps2_clk_oe_o  = clkOe_q;
  assign ps2_data_oe_o = dataOe_q;
  assign tx_done_o     = txDone_q;
  assign tx_err_o      = txErr_q;

endmodule
